// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word alias, instruction opcode encodings (including the
// LL/SC pair) and the writeback-select encoding carried down the pipeline.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDI  = 6'h08,
    ADDIU = 6'h09,
    SLTI  = 6'h0a,
    SLTIU = 6'h0b,
    ANDI  = 6'h0c,
    ORI   = 6'h0d,
    XORI  = 6'h0e,
    LUI   = 6'h0f,
    LW    = 6'h23,
    SW    = 6'h2b,
    LL    = 6'h30,
    SC    = 6'h38,
    HALT  = 6'h3f
  } opcode_t;

  // Writeback select: which value the WB stage writes to the register file.
  localparam logic [1:0] MTR_ALU  = 2'd0;
  localparam logic [1:0] MTR_LOAD = 2'd1;
  localparam logic [1:0] MTR_PC   = 2'd2;

endpackage

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register.
// Ports: CLK, nRST (async active-low); flush clears the register, en loads
// it; rdat/aluout/pcAddr/WEN/wsel/memtoreg/halt/opcode are the next-stage
// values; wb_* are the registered outputs consumed by writeback/forwarding.
// wb_halt is sticky: once set it survives flushes and is cleared only by
// reset, so a halted core cannot be restarted by a squash.
module mem_wb_latch
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              en,
  input  logic [DATA_W-1:0] rdat,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcAddr,
  input  logic              WEN,
  input  logic [REG_AW-1:0] wsel,
  input  logic [1:0]        memtoreg,
  input  logic              halt,
  input  opcode_t           opcode,
  output logic [DATA_W-1:0] wb_rdat,
  output logic [DATA_W-1:0] wb_aluout,
  output logic [DATA_W-1:0] wb_pcAddr,
  output logic              wb_WEN,
  output logic [REG_AW-1:0] wb_wsel,
  output logic [1:0]        wb_memtoreg,
  output logic              wb_halt,
  output opcode_t           wb_opcode
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_rdat     <= '0;
      wb_aluout   <= '0;
      wb_pcAddr   <= '0;
      wb_WEN      <= 1'b0;
      wb_wsel     <= '0;
      wb_memtoreg <= '0;
      wb_halt     <= 1'b0;
      wb_opcode   <= opcode_t'(0);
    end else if (flush) begin
      wb_rdat     <= '0;
      wb_aluout   <= '0;
      wb_pcAddr   <= '0;
      wb_WEN      <= 1'b0;
      wb_wsel     <= '0;
      wb_memtoreg <= '0;
      wb_opcode   <= opcode_t'(0);
    end else if (en) begin
      wb_rdat     <= rdat;
      wb_aluout   <= aluout;
      wb_pcAddr   <= pcAddr;
      wb_WEN      <= WEN;
      wb_wsel     <= wsel;
      wb_memtoreg <= memtoreg;
      wb_halt     <= wb_halt | halt;
      wb_opcode   <= opcode;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues data-cache requests from the EX/MEM latch, stalls the
// front of the pipeline while an access is outstanding, and fills MEM/WB.
// Ports: CLK, nRST (async active-low); exm_* EX/MEM inputs; flush/wb_en from
// the hazard unit; dmemREN/dmemWEN/dmemaddr/dmemstore request to the cache,
// dhit/dmemload response; mem_stall to the hazard unit; wb_* MEM/WB outputs;
// fsm_state exposes the access FSM (0 IDLE, 1 WAIT, 2 DONE).
// Optional: define LLSC_EN for load-linked/store-conditional support, which
// adds snoop_inv/snoop_addr.
//
// Handshake: a request is held on dmemREN/dmemWEN until the cycle dhit is
// high; that cycle completes the access and mem_stall is already low in it.
// MEM/WB advances on any cycle with wb_en & ~mem_stall.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [DATA_W-1:0] exm_aluout,
  input  logic [DATA_W-1:0] exm_wdat,
  input  logic              exm_dREN,
  input  logic              exm_dWEN,
  input  logic              exm_WEN,
  input  logic [REG_AW-1:0] exm_wsel,
  input  logic [1:0]        exm_memtoreg,
  input  logic [DATA_W-1:0] exm_pcAddr,
  input  logic              exm_halt,
  input  opcode_t           exm_opcode,
  input  logic              flush,
  input  logic              wb_en,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              mem_stall,
  output logic [DATA_W-1:0] wb_rdat,
  output logic [DATA_W-1:0] wb_aluout,
  output logic [DATA_W-1:0] wb_pcAddr,
  output logic              wb_WEN,
  output logic [REG_AW-1:0] wb_wsel,
  output logic [1:0]        wb_memtoreg,
  output logic              wb_halt,
  output opcode_t           wb_opcode,
  output logic [1:0]        fsm_state
`ifdef LLSC_EN
  ,
  input  logic              snoop_inv,
  input  logic [DATA_W-1:0] snoop_addr
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t            state, next_state;
  logic              memop, capture, latch_en, is_sc, sc_ok, sc_block;
  logic [DATA_W-1:0] held_load, load_val, rdat_next;

  assign is_sc = (exm_opcode == SC);

`ifdef LLSC_EN
  logic              linkvalid;
  logic [DATA_W-1:0] linkaddr;
  assign sc_ok    = linkvalid && (linkaddr == exm_aluout);
  // A failing SC never reaches the cache and completes like an ALU op.
  assign sc_block = is_sc & ~sc_ok;
`else
  assign sc_ok    = 1'b0;
  assign sc_block = 1'b0;
`endif

  assign memop     = (exm_dREN | exm_dWEN) & ~wb_halt & ~sc_block;
  assign dmemaddr  = exm_aluout;
  assign dmemstore = exm_wdat;
  assign fsm_state = state;

  // SC returns its success flag instead of cache data; capturing that flag
  // into the held register keeps it valid if MEM/WB is stalled into DONE.
  assign load_val  = is_sc ? {{(DATA_W-1){1'b0}}, sc_ok} : dmemload;
  assign rdat_next = (state == DONE) ? held_load : load_val;
  assign latch_en  = wb_en & ~mem_stall;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_stall  = 1'b0;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          dmemWEN = exm_dWEN;
          dmemREN = exm_dREN & ~exm_dWEN;
          if (dhit) begin
            capture = 1'b1;
            if (!wb_en) next_state = DONE;
          end else begin
            mem_stall  = 1'b1;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        dmemWEN = exm_dWEN;
        dmemREN = exm_dREN & ~exm_dWEN;
        if (dhit) begin
          capture    = 1'b1;
          next_state = wb_en ? IDLE : DONE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      DONE: begin
        if (wb_en) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        held_load <= '0;
    else if (capture) held_load <= load_val;
  end

`ifdef LLSC_EN
  // Clears are ordered after the LL set so a same-cycle invalidate wins.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      linkvalid <= 1'b0;
      linkaddr  <= '0;
    end else begin
      if (capture && exm_opcode == LL) begin
        linkvalid <= 1'b1;
        linkaddr  <= exm_aluout;
      end
      if (capture && is_sc) linkvalid <= 1'b0;
      if (capture && exm_opcode == SW && exm_aluout == linkaddr) linkvalid <= 1'b0;
      if (snoop_inv && snoop_addr == linkaddr) linkvalid <= 1'b0;
    end
  end
`endif

  mem_wb_latch #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mem_wb (
    .CLK         (CLK),
    .nRST        (nRST),
    .flush       (flush),
    .en          (latch_en),
    .rdat        (rdat_next),
    .aluout      (exm_aluout),
    .pcAddr      (exm_pcAddr),
    .WEN         (exm_WEN),
    .wsel        (exm_wsel),
    .memtoreg    (exm_memtoreg),
    .halt        (exm_halt),
    .opcode      (exm_opcode),
    .wb_rdat     (wb_rdat),
    .wb_aluout   (wb_aluout),
    .wb_pcAddr   (wb_pcAddr),
    .wb_WEN      (wb_WEN),
    .wb_wsel     (wb_wsel),
    .wb_memtoreg (wb_memtoreg),
    .wb_halt     (wb_halt),
    .wb_opcode   (wb_opcode)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: each access is described as a transaction
// (miss length, cycles MEM/WB is held) and the bench derives the expected
// stall/request pattern and MEM/WB contents from that description.
module tb_mem_stage;
  import cpu_types_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [DW-1:0] exm_aluout, exm_wdat, exm_pcAddr, dmemaddr, dmemstore, dmemload;
  logic          exm_dREN, exm_dWEN, exm_WEN, exm_halt, flush, wb_en, dhit;
  logic [AW-1:0] exm_wsel, wb_wsel;
  logic [1:0]    exm_memtoreg, wb_memtoreg, fsm_state;
  opcode_t       exm_opcode, wb_opcode;
  logic          dmemREN, dmemWEN, mem_stall, wb_WEN, wb_halt;
  logic [DW-1:0] wb_rdat, wb_aluout, wb_pcAddr;
`ifdef LLSC_EN
  logic          snoop_inv;
  logic [DW-1:0] snoop_addr;
`endif

  mem_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .CLK(CLK), .nRST(nRST),
    .exm_aluout(exm_aluout), .exm_wdat(exm_wdat), .exm_dREN(exm_dREN),
    .exm_dWEN(exm_dWEN), .exm_WEN(exm_WEN), .exm_wsel(exm_wsel),
    .exm_memtoreg(exm_memtoreg), .exm_pcAddr(exm_pcAddr), .exm_halt(exm_halt),
    .exm_opcode(exm_opcode), .flush(flush), .wb_en(wb_en),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .mem_stall(mem_stall), .wb_rdat(wb_rdat), .wb_aluout(wb_aluout),
    .wb_pcAddr(wb_pcAddr), .wb_WEN(wb_WEN), .wb_wsel(wb_wsel),
    .wb_memtoreg(wb_memtoreg), .wb_halt(wb_halt), .wb_opcode(wb_opcode),
    .fsm_state(fsm_state)
`ifdef LLSC_EN
    , .snoop_inv(snoop_inv), .snoop_addr(snoop_addr)
`endif
  );

  // ---------------- model state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic          check_on = 1'b0;
  logic          rdat_pending = 1'b0;
  logic          m_stall, m_ren, m_wen;
  logic [DW-1:0] m_addr, m_store, m_aluout, m_pc;
  logic          m_WEN, m_halt;
  logic [AW-1:0] m_wsel;
  logic [1:0]    m_mtr;
  opcode_t       m_opc;
  int            stall_cnt, wen_cnt, ren_cnt;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    if (check_on) begin
      chk("mem_stall", {31'b0, mem_stall}, {31'b0, m_stall});
      chk("dmemREN", {31'b0, dmemREN}, {31'b0, m_ren});
      chk("dmemWEN", {31'b0, dmemWEN}, {31'b0, m_wen});
      chk("dmemaddr", dmemaddr, m_addr);
      chk("dmemstore", dmemstore, m_store);
      chk("wb_aluout", wb_aluout, m_aluout);
      chk("wb_pcAddr", wb_pcAddr, m_pc);
      chk("wb_WEN", {31'b0, wb_WEN}, {31'b0, m_WEN});
      chk("wb_wsel", {27'b0, wb_wsel}, {27'b0, m_wsel});
      chk("wb_memtoreg", {30'b0, wb_memtoreg}, {30'b0, m_mtr});
      chk("wb_halt", {31'b0, wb_halt}, {31'b0, m_halt});
      chk("wb_opcode", {26'b0, wb_opcode}, {26'b0, m_opc});
      if (rdat_pending) begin
        rdat_pending = 1'b0;
        if (exp_q.size() == 0) chk("wb_rdat_queue", 32'd0, 32'd1);
        else chk("wb_rdat", wb_rdat, exp_q.pop_front());
      end
      if (mem_stall) stall_cnt++;
      if (dmemWEN)   wen_cnt++;
      if (dmemREN)   ren_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_exm(input opcode_t opc, input logic [DW-1:0] alu, wdat,
                         input logic ren, wen, wr, input logic [AW-1:0] ws,
                         input logic [1:0] mtr, input logic [DW-1:0] pc, input logic hlt);
    exm_opcode = opc; exm_aluout = alu; exm_wdat = wdat; exm_dREN = ren;
    exm_dWEN = wen; exm_WEN = wr; exm_wsel = ws; exm_memtoreg = mtr;
    exm_pcAddr = pc; exm_halt = hlt;
    m_addr = alu; m_store = wdat;
  endtask

  task automatic step(input logic s, r, w);
    m_stall = s; m_ren = r; m_wen = w;
    @(posedge CLK); #1;
  endtask

  // Expected MEM/WB after an advancing edge.
  task automatic latch_model(input opcode_t opc, input logic [DW-1:0] alu, pc,
                             input logic wr, input logic [AW-1:0] ws, input logic [1:0] mtr,
                             input logic hlt, input logic chk_r, input logic [DW-1:0] exp_r);
    m_opc = opc; m_aluout = alu; m_pc = pc; m_WEN = wr; m_wsel = ws; m_mtr = mtr;
    m_halt = m_halt | hlt;
    if (chk_r) begin
      exp_q.push_back(exp_r);
      rdat_pending = 1'b1;
    end
  endtask

  // One instruction through MEM. expect_req: whether the cache must see it.
  // miss: dhit-low cycles before the hit. hold: wb_en-low cycles from the hit.
  task automatic txn(input opcode_t opc, input logic [DW-1:0] alu, wdat,
                     input logic ren, wen, wr, input logic [AW-1:0] ws, input logic [1:0] mtr,
                     input logic [DW-1:0] pc, input logic hlt, input logic expect_req,
                     input int miss, input int hold, input logic [DW-1:0] load,
                     input logic chk_r, input logic [DW-1:0] exp_r);
    logic er, ew;
    er = expect_req & ren & ~wen;
    ew = expect_req & wen;
    set_exm(opc, alu, wdat, ren, wen, wr, ws, mtr, pc, hlt);
    flush = 1'b0;
    if (!expect_req) begin
      dhit = 1'b0; dmemload = load; wb_en = 1'b1;
      step(1'b0, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < miss; i++) begin
        dhit = 1'b0; dmemload = $urandom; wb_en = 1'b1;
        step(1'b1, er, ew);
      end
      dhit = 1'b1; dmemload = load; wb_en = (hold == 0);
      step(1'b0, er, ew);
      for (int h = 1; h <= hold; h++) begin
        chk("done_state", {30'b0, fsm_state}, 32'd2);
        dhit = 1'b0; dmemload = $urandom; wb_en = (h == hold);
        step(1'b0, 1'b0, 1'b0);
      end
    end
    latch_model(opc, alu, pc, wr, ws, mtr, hlt, chk_r, exp_r);
  endtask

  task automatic bubble(input logic en);
    set_exm(RTYPE, '0, '0, 1'b0, 1'b0, 1'b0, '0, 2'd0, '0, 1'b0);
    flush = 1'b0; dhit = 1'b0; wb_en = en; dmemload = $urandom;
    step(1'b0, 1'b0, 1'b0);
    if (en) latch_model(RTYPE, '0, '0, 1'b0, '0, 2'd0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0; flush = 1'b0; wb_en = 1'b0; dhit = 1'b0; dmemload = '0;
`ifdef LLSC_EN
    snoop_inv = 1'b0; snoop_addr = '0;
`endif
    set_exm(RTYPE, '0, '0, 1'b0, 1'b0, 1'b0, '0, 2'd0, '0, 1'b0);
    m_aluout = '0; m_pc = '0; m_WEN = 1'b0; m_wsel = '0; m_mtr = '0;
    m_halt = 1'b0; m_opc = RTYPE; m_stall = 1'b0; m_ren = 1'b0; m_wen = 1'b0;
    stall_cnt = 0; wen_cnt = 0; ren_cnt = 0;

    // Reset values
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_wb_rdat", wb_rdat, 32'd0);
    chk("rst_wb_aluout", wb_aluout, 32'd0);
    chk("rst_wb_halt", {31'b0, wb_halt}, 32'd0);
    chk("rst_wb_WEN", {31'b0, wb_WEN}, 32'd0);
    chk("rst_wb_opcode", {26'b0, wb_opcode}, 32'd0);
    chk("rst_fsm", {30'b0, fsm_state}, 32'd0);
    nRST = 1'b1;
    check_on = 1'b1;

    // LW hit, zero wait
    txn(LW, 32'h100, 32'h0, 1, 0, 1, 5'd5, MTR_LOAD, 32'h44, 0, 1, 0, 0,
        32'hDEADBEEF, 1, 32'hDEADBEEF);
    chk("lw_rdat_lit", wb_rdat, 32'hDEADBEEF);
    chk("lw_mtr_lit", {30'b0, wb_memtoreg}, 32'd1);

    // SW with 3-cycle miss
    stall_cnt = 0; wen_cnt = 0;
    txn(SW, 32'h200, 32'hCAFEF00D, 0, 1, 0, 5'd0, MTR_ALU, 32'h48, 0, 1, 3, 0,
        32'h0, 0, 32'h0);
    chk("sw_stall_cycles", stall_cnt, 32'd3);
    chk("sw_wen_cycles", wen_cnt, 32'd4);

    // LW hit while MEM/WB is held for 2 cycles
    txn(LW, 32'h104, 32'h0, 1, 0, 1, 5'd9, MTR_LOAD, 32'h4C, 0, 1, 0, 2,
        32'h12345678, 1, 32'h12345678);
    chk("held_rdat_lit", wb_rdat, 32'h12345678);

    // Non-memory ops
    txn(ADDI, 32'h0000_0777, 32'h1, 0, 0, 1, 5'd3, MTR_ALU, 32'h50, 0, 0, 0, 0,
        32'h0, 0, 32'h0);
    txn(JAL, 32'h0, 32'h0, 0, 0, 1, 5'd31, MTR_PC, 32'h400, 0, 0, 0, 0,
        32'h0, 0, 32'h0);
    // Both enables high: store wins, read must not be issued
    txn(SW, 32'h208, 32'h0BAD_F00D, 1, 1, 0, 5'd0, MTR_ALU, 32'h404, 0, 1, 1, 0,
        32'h0, 0, 32'h0);

    // Flush during WAIT
    set_exm(LW, 32'h108, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, MTR_LOAD, 32'h408, 1'b0);
    dhit = 1'b0; wb_en = 1'b1; flush = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    latch_model(RTYPE, '0, '0, 1'b0, '0, 2'd0, 1'b0, 1'b1, 32'd0);
    chk("flush_fsm_idle", {30'b0, fsm_state}, 32'd0);
    bubble(1'b0);
    chk("flush_wb_pc_lit", wb_pcAddr, 32'd0);

`ifdef LLSC_EN
    // LL, snooped away, SC fails without touching the cache
    txn(LL, 32'h300, 32'h0, 1, 0, 1, 5'd4, MTR_LOAD, 32'h500, 0, 1, 1, 0,
        32'h0000AAAA, 1, 32'h0000AAAA);
    snoop_inv = 1'b1; snoop_addr = 32'h300;
    bubble(1'b1);
    snoop_inv = 1'b0;
    wen_cnt = 0;
    txn(SC, 32'h300, 32'h77, 0, 1, 1, 5'd4, MTR_LOAD, 32'h504, 0, 0, 0, 0,
        32'hFFFFFFFF, 1, 32'd0);
    chk("sc_fail_no_wen", wen_cnt, 32'd0);
    // Same without snoop: SC stores and reports success
    txn(LL, 32'h300, 32'h0, 1, 0, 1, 5'd4, MTR_LOAD, 32'h508, 0, 1, 0, 0,
        32'h0000BBBB, 1, 32'h0000BBBB);
    txn(SC, 32'h300, 32'h77, 0, 1, 1, 5'd4, MTR_LOAD, 32'h50C, 0, 1, 1, 0,
        32'hFFFFFFFF, 1, 32'd1);
    chk("sc_ok_lit", wb_rdat, 32'd1);
    // Link consumed: a second SC fails
    txn(SC, 32'h300, 32'h78, 0, 1, 1, 5'd4, MTR_LOAD, 32'h510, 0, 0, 0, 0,
        32'hFFFFFFFF, 1, 32'd0);
`else
    // SC behaves as a store and reports 0
    txn(SC, 32'h300, 32'h77, 0, 1, 1, 5'd4, MTR_LOAD, 32'h500, 0, 1, 0, 0,
        32'hFFFFFFFF, 1, 32'd0);
    chk("sc_rdat_lit", wb_rdat, 32'd0);
`endif

    // Halt, then a load that must never reach the cache
    txn(HALT, 32'h0, 32'h0, 0, 0, 0, 5'd0, MTR_ALU, 32'h600, 1, 0, 0, 0,
        32'h0, 0, 32'h0);
    chk("halt_lit", {31'b0, wb_halt}, 32'd1);
    ren_cnt = 0;
    txn(LW, 32'h100, 32'h0, 1, 0, 1, 5'd6, MTR_LOAD, 32'h604, 0, 0, 0, 0,
        32'h11111111, 0, 32'h0);
    bubble(1'b1);
    chk("halt_no_ren", ren_cnt, 32'd0);
    chk("halt_sticky_lit", {31'b0, wb_halt}, 32'd1);

    check_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline.
- Consumes the EX/MEM latch outputs (ALU result, store data, load/store enables, writeback controls, halt, PC+4, opcode).
- Runs the data-cache request/hit handshake and raises a pipeline stall while an access is outstanding.
- Registers results into the MEM/WB latch consumed by writeback and forwarding.

Parameters:
- DATA_W, 32, datapath/address width
- REG_AW, 5, register-select width

Ports:
- CLK  input  1  clock
- nRST  input  1  async active-low reset
- exm_aluout  input  DATA_W  ALU result / effective address
- exm_wdat  input  DATA_W  store data
- exm_dREN  input  1  load request
- exm_dWEN  input  1  store request
- exm_WEN  input  1  register write enable
- exm_wsel  input  REG_AW  destination register
- exm_memtoreg  input  2  writeback select: 0 alu, 1 load, 2 pc+4
- exm_pcAddr  input  DATA_W  PC+4 for JAL
- exm_halt  input  1  halt marker
- exm_opcode  input  opcode_t  instruction opcode
- flush  input  1  squash MEM/WB contents
- wb_en  input  1  MEM/WB latch enable from hazard unit
- dmemREN  output  1  cache read request
- dmemWEN  output  1  cache write request
- dmemaddr  output  DATA_W  cache address
- dmemstore  output  DATA_W  cache store data
- dhit  input  1  cache access complete
- dmemload  input  DATA_W  cache load data
- mem_stall  output  1  freeze PC/IF/ID/EX/EX-MEM latches
- wb_rdat, wb_aluout, wb_pcAddr  output  DATA_W  MEM/WB data
- wb_WEN  output  1  MEM/WB register write enable
- wb_wsel  output  REG_AW  MEM/WB destination register
- wb_memtoreg  output  2  MEM/WB writeback select
- wb_halt  output  1  MEM/WB halt marker
- wb_opcode  output  opcode_t  MEM/WB opcode

Behaviour:
- Reset, asynchronous: all wb_* = 0, wb_opcode = opcode_t'(0), FSM = IDLE, held-load register = 0.
- FSM states: IDLE, WAIT, DONE.
- memop = (exm_dREN | exm_dWEN) & ~wb_halt.
- Request outputs:
  - dmemREN/dmemWEN follow exm_dREN/exm_dWEN in IDLE (when memop) and in WAIT; they are 0 in DONE.
  - dmemaddr = exm_aluout, dmemstore = exm_wdat at all times.
  - dREN and dWEN both high is illegal; dWEN takes priority and dmemREN is driven 0.
- IDLE:
  - memop & dhit: zero-wait access. mem_stall = 0, dmemload is captured. Stay IDLE if wb_en, else go DONE.
  - memop & ~dhit: mem_stall = 1, go WAIT.
- WAIT:
  - Request held, mem_stall = 1 until dhit.
  - On the dhit cycle mem_stall = 0 and dmemload is captured into the held-load register.
  - Next state IDLE if wb_en, else DONE.
- DONE:
  - Access completed, but the MEM/WB latch has not advanced. No re-issue of the request, mem_stall = 0.
  - Return to IDLE on a cycle with wb_en = 1.
- MEM/WB update, priority order:
  1. flush: all wb_* cleared on the next edge. FSM also returns to IDLE, abandoning any WAIT; the cache drops the request on the next cycle.
  2. wb_en & ~mem_stall: latch exm_* fields. wb_rdat = dmemload in the dhit cycle, or the held-load register in DONE.
  3. Otherwise: hold.
- wb_halt is sticky: once 1, it is cleared only by reset. No memory requests are issued after halt.
- A store never sets wb_WEN unless the upstream exm_WEN is set; the block passes it through unmodified.
- Latency: 1 cycle on hit; N+1 cycles for an N-cycle miss.

Optional Feature:
- Macro LLSC_EN adds load-linked/store-conditional support with a link register: linkvalid plus linkaddr[DATA_W-1:0].
- Extra port when enabled: snoop_inv (input, 1) with snoop_addr (input, DATA_W). A match on linkaddr clears linkvalid.
- LL: normal load; on completion set linkvalid = 1, linkaddr = exm_aluout.
- SC, link valid and address matching: performs the store, wb_rdat = 1, clears linkvalid.
- SC, otherwise: no dmemWEN is issued, wb_rdat = 0, latency 1 cycle.
- Any completed SW to linkaddr clears linkvalid.
- Without the macro: LL is treated as LW, SC as SW with wb_rdat = 0, and no link state exists.

Decomposition:
- opcode_t (LL/SC encodings included), the word_t alias and the memtoreg encoding constants belong in cpu_types_pkg.
- The FSM state enum stays local.
- One sub-module is natural: mem_wb_latch, a pure MEM/WB register with flush/enable. The FSM and request logic stay in mem_stage.

Test Plan:
- LW of 0x100, dhit in same cycle, wb_en = 1 -> no stall; next edge wb_rdat = dmemload (0xDEADBEEF), wb_memtoreg = 1.
- SW of 0xCAFEF00D to 0x200, dhit after 3 cycles -> mem_stall high for 3 cycles, dmemWEN high 4 cycles, then wb latched.
- LW hits while wb_en = 0 for 2 cycles -> FSM enters DONE, dmemREN = 0; wb_rdat = held 0x12345678 when wb_en rises.
- flush during WAIT -> wb_* = 0 next edge, FSM = IDLE, mem_stall = 0.
- Halt passes through, then exm_dREN = 1 -> wb_halt stays 1, dmemREN never asserted.
- LLSC_EN: LL 0x300, snoop_inv at 0x300, SC 0x300 -> no dmemWEN, wb_rdat = 0. Repeat without snoop -> store issued, wb_rdat = 1.
